// File: rtl/riu_pkg.sv
// Shared definitions for the instruction encoder.
// Holds the aluop codes, RISC-V opcode/funct3/funct7 fields, the NOP word,
// the encoder FSM state enum, the descriptor/encode-result structs and the
// descriptor-to-word encode function used by instr_encoder.
package riu_pkg;

    localparam int WORD_W     = 32;
    localparam int ADDR_W     = 10;
    localparam int COUNT_W    = 11;
    localparam int FIFO_DEPTH = 2;
    localparam int PAD_WORDS  = 2;

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    // aluop codes as presented on in_aluop
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_ADD = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_MUL = 4'b0101;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SLT = 4'b1100;

    localparam logic [6:0] OPC_R = 7'h33;
    localparam logic [6:0] OPC_I = 7'h13;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_SUB  = 7'h20;
    localparam logic [6:0] F7_MUL  = 7'h01;

    // addi x0, x0, 0
    localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, RUN, PAD, DONE} state_t;

    typedef struct packed {
        logic [3:0]  aluop;
        logic        alusrc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] imm;
    } desc_t;

    typedef struct packed {
        logic              ok;
        logic [WORD_W-1:0] word;
    } enc_t;

    // Unsupported aluop/alusrc pairs come back with ok=0 and a zero word.
    function automatic enc_t encode(input desc_t d);
        enc_t        e;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] imm;
        e.ok = 1'b1;
        f3   = F3_ADD;
        f7   = F7_BASE;
        imm  = d.imm;
        if (!d.alusrc) begin
            case (d.aluop)
                ALU_ADD: f3 = F3_ADD;
                ALU_SUB: f7 = F7_SUB;
                ALU_MUL: f7 = F7_MUL;
                ALU_SLT: f3 = F3_SLT;
                ALU_AND: f3 = F3_AND;
                ALU_SLL: f3 = F3_SLL;
                default: e.ok = 1'b0;
            endcase
            e.word = {f7, d.rs2, d.rs1, f3, d.rd, OPC_R};
        end else begin
            case (d.aluop)
                ALU_AND: f3 = F3_AND;
                // SLLI: upper immediate bits are the funct7 slot and must be zero
                ALU_SLL: begin
                    f3  = F3_SLL;
                    imm = {7'b0, d.imm[4:0]};
                end
                default: e.ok = 1'b0;
            endcase
            e.word = {imm, d.rs1, f3, d.rd, OPC_I};
        end
        if (!e.ok) e.word = '0;
        return e;
    endfunction

endpackage

// File: rtl/enc_fifo.sv
// Small synchronous FIFO buffering encoded words toward instruction memory.
// Ports: clk, rst_n (async low); push/wdata write side; pop read side with
// rdata showing the head entry; flush empties the FIFO and wins over push;
// full/empty status. DEPTH must be a power of two (pointers wrap naturally).
module enc_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: turns ALU descriptors into RV32 R/I-type words and
// writes them to consecutive instruction-memory word addresses.
// Ports:
//   clk, rst_n (async low)
//   start            begin a program (honoured in IDLE/DONE only)
//   in_valid/in_ready descriptor handshake, in_last marks the final one
//   in_aluop, in_alusrc, in_rd, in_rs1, in_rs2, in_imm  descriptor fields
//   imem_we/imem_ready  write handshake, imem_addr word address, imem_wdata
//   busy, done, err (sticky), ovf (sticky), count (words written)
// Build option: INSTR_ENC_NOP_PAD_EN appends two NOP words after the last
// real word of each program; without it the PAD state is never entered.
module instr_encoder
    import riu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                in_last,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          in_aluop,
    input  logic                in_alusrc,
    input  logic [4:0]          in_rd,
    input  logic [4:0]          in_rs1,
    input  logic [4:0]          in_rs2,
    input  logic [11:0]         in_imm,
    output logic                imem_we,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic [WORD_W-1:0]   imem_wdata,
    input  logic                imem_ready,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                ovf,
    output logic [COUNT_W-1:0]  count
);
    state_t            state;
    logic              last_seen;
    logic              fifo_full;
    logic              fifo_empty;
    logic              accept;
    logic              wr_done;
    logic              push;
    logic              pad_push;
    logic              flush;
    logic [WORD_W-1:0] push_data;
    logic [WORD_W-1:0] head;
    desc_t             desc;
    enc_t              enc;

    assign desc = '{aluop: in_aluop, alusrc: in_alusrc, rd: in_rd,
                    rs1: in_rs1, rs2: in_rs2, imm: in_imm};
    assign enc  = encode(desc);

    // !fifo_full also keeps an accept out of the cycle a full FIFO pops
    assign in_ready   = (state == RUN) && !fifo_full && !last_seen && !ovf;
    assign accept     = in_valid && in_ready;
    assign imem_we    = !fifo_empty;
    assign imem_wdata = fifo_empty ? '0 : head;
    assign wr_done    = imem_we && imem_ready;
    // The write at the last address ends the program: anything still
    // queued behind it is dropped rather than wrapped to address 0.
    assign flush      = wr_done && (imem_addr == ADDR_LAST);
    assign push       = (accept && enc.ok) || pad_push;
    assign push_data  = pad_push ? NOP_WORD : enc.word;

`ifdef INSTR_ENC_NOP_PAD_EN
    logic [1:0] pad_cnt;
    assign pad_push = (state == PAD) && (pad_cnt != 2'(PAD_WORDS)) && !fifo_full && !ovf;
`else
    assign pad_push = 1'b0;
`endif

    enc_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(WORD_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (push_data),
        .pop   (wr_done),
        .flush (flush),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_seen <= 1'b0;
            imem_addr <= '0;
            count     <= '0;
            err       <= 1'b0;
            ovf       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef INSTR_ENC_NOP_PAD_EN
            pad_cnt   <= '0;
`endif
        end else begin
            if (wr_done) begin
                count <= count + 1'b1;
                // address saturates at the top; ovf marks the overflow
                if (imem_addr == ADDR_LAST) ovf <= 1'b1;
                else                        imem_addr <= imem_addr + 1'b1;
            end
            if (accept && !enc.ok) err <= 1'b1;
            if (accept && in_last) last_seen <= 1'b1;

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        imem_addr <= '0;
                        count     <= '0;
                        err       <= 1'b0;
                        ovf       <= 1'b0;
                        last_seen <= 1'b0;
                    end
                end
                RUN: begin
                    if ((last_seen || ovf) && fifo_empty) begin
`ifdef INSTR_ENC_NOP_PAD_EN
                        if (!ovf) begin
                            state   <= PAD;
                            pad_cnt <= '0;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
`else
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
`endif
                    end
                end
                PAD: begin
`ifdef INSTR_ENC_NOP_PAD_EN
                    if (pad_push) pad_cnt <= pad_cnt + 1'b1;
                    if ((pad_cnt == 2'(PAD_WORDS) || ovf) && fifo_empty) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
`else
                    state <= IDLE;
                    busy  <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have ports: clk input 1, single clock; all state on rising edge.
REQ-002 SHALL have port rst_n input 1: asynchronous, active-low reset.
REQ-003 SHALL have ports start input 1 and in_last input 1: start begins a program; in_last marks the final descriptor.
REQ-004 SHALL have ports in_valid input 1 and in_ready output 1: descriptor handshake.
REQ-005 SHALL have descriptor ports in_aluop input 4, in_alusrc input 1, in_rd/in_rs1/in_rs2 input 5 each, and in_imm input 12.
REQ-006 SHALL have ports imem_we output 1, imem_addr output 10 (word address), imem_wdata output 32 and imem_ready input 1: memory write handshake.
REQ-007 SHALL have status outputs busy 1, done 1, err 1 (sticky), ovf 1 (sticky) and count 11 (words written).

Function
REQ-008 SHALL use FSM states IDLE, RUN, PAD, DONE; transitions: IDLE->RUN on start; RUN->PAD (or DONE) once in_last is accepted and the FIFO drains; PAD->DONE after padding; DONE->RUN on start.
REQ-009 SHALL on start clear imem_addr, count, err, ovf and done; start while in RUN/PAD SHALL be ignored.
REQ-010 SHALL accept a descriptor when in_valid && in_ready; in_ready = (state==RUN) && FIFO not full && !in_last_seen && !ovf; no accept in the same cycle as a full-FIFO pop.
REQ-011 SHALL encode R-type (opcode 0x33) for alusrc=0: aluop 0011 ADD f3 000 f7 0x00; 0100 SUB f3 000 f7 0x20; 0101 MUL f3 000 f7 0x01; 1100 SLT f3 010; 0000 AND f3 111; 1000 SLL f3 001 (f7 0x00 except as stated).
REQ-012 SHALL encode I-type (opcode 0x13) for alusrc=1: aluop 0000 ANDI f3 111 imm[11:0]; 1000 SLLI f3 001 with imm[11:5] forced 0 and shamt=in_imm[4:0].
REQ-013 SHALL, for any other aluop/alusrc pair, set err, write no word, and still consume the descriptor (including in_last).
REQ-014 SHALL buffer encoded words in a 2-entry FIFO; imem_we = FIFO not empty; a write completes when imem_we && imem_ready.
REQ-015 SHALL have latency: a descriptor accepted in cycle N is presented on imem_we/imem_wdata at N+1 at the earliest; imem_wdata/imem_addr SHALL hold stable while imem_ready=0.
REQ-016 SHALL increment imem_addr and count by 1 per completed write; a completed write at address 1023 SHALL set ovf, block further accepts, and go to DONE after the FIFO drains (no wrap-around).
REQ-017 SHALL keep busy=1 in RUN and PAD, and done=1 only in DONE.

Reset
REQ-018 SHALL on rst_n=0 immediately force: state IDLE; FIFO empty; imem_we=0, imem_addr=0, imem_wdata=0; in_ready=0; busy/done/err/ovf=0; count=0.
REQ-019 SHALL discard FIFO contents on reset mid-program; no partial write.

Configuration
REQ-020 SHALL, with INSTR_ENC_NOP_PAD_EN defined, make PAD emit two NOP words (0x00000013) after the last real word, subject to imem_ready and ovf rules, to drain the 3-stage pipeline.
REQ-021 SHALL, without INSTR_ENC_NOP_PAD_EN, have PAD unreachable; RUN goes directly to DONE.

Structure
REQ-022 SHALL place aluop codes, opcode/funct3/funct7 constants, the NOP word and the FSM state enum in shared package riu_pkg.
REQ-023 SHALL implement the FIFO as sub-module enc_fifo (depth 2, width 32).

Verification
REQ-024 SHALL test: start; ADD rd=1 rs1=2 rs2=3 with in_last; imem_ready=1 -> word 0x003100B3 at addr 0; done; count=1.
REQ-025 SHALL test: SUB x5,x6,x7 then ANDI x1,x2,0xFF -> 0x407302B3 at addr 0, 0x0FF17093 at addr 1.
REQ-026 SHALL test: SLLI with in_imm=0xFE3 -> imm field 0x003 (0x00311093 for rd=1 rs1=2); aluop 0100 with alusrc=1 -> err=1, no write.
REQ-027 SHALL test: imem_ready=0 for 5 cycles with 3 descriptors offered -> in_ready=0 after 2 accepts; data stable; no loss or reorder after release.
REQ-028 SHALL test: 1025 descriptors -> ovf=1 after the addr 1023 write; count=1024; no further accepts.
REQ-029 SHALL test: with INSTR_ENC_NOP_PAD_EN, a single MUL program -> 3 words with NOPs at addr 1-2; also rst_n pulse mid-stall -> all outputs zero immediately.
